// File: rtl/mem_arbiter.sv
// Arbiter sharing the byte-serial MemUnit between instruction fetch and the load/store buffer.
// Define MEM_ARB_FIXED_PRIO_EN for fixed LSB-first priority; default build is round-robin.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              rob_clear,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [2:0]        lsb_len,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  output logic              mu_valid,
  output logic              mu_wr,
  output logic [ADDR_W-1:0] mu_addr,
  output logic [2:0]        mu_len,
  output logic [31:0]       mu_wdata,
  input  logic [31:0]       mu_rdata,
  input  logic              mu_ready
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WAIT, S_DONE} state_t;
  typedef enum logic {OWN_IF, OWN_LSB} owner_t;

  state_t      state;
  owner_t      owner;
  logic [1:0]  cnt;
  logic [2:0]  beats;
  logic        stall;
  logic        last_beat;
  logic        grant_lsb;
  logic [31:0] load_ext;
`ifndef MEM_ARB_FIXED_PRIO_EN
  owner_t      last;
`endif

  function automatic logic [2:0] beats_for(input logic [1:0] size);
    case (size)
      2'b00:   beats_for = 3'd1;
      2'b01:   beats_for = 3'd2;
      default: beats_for = 3'd4;
    endcase
  endfunction

  // Stores to the UART window may not advance while its buffer is full.
  always_comb begin
    stall     = mu_wr && (mu_addr[17:16] == 2'b11) && io_buffer_full;
    last_beat = ({1'b0, cnt} == (beats - 3'd1));
`ifdef MEM_ARB_FIXED_PRIO_EN
    grant_lsb = lsb_req;
`else
    grant_lsb = lsb_req && (!if_req || (last == OWN_IF));
`endif
  end

  always_comb begin
    load_ext = '0;
    if (!mu_wr) begin
      case (mu_len[1:0])
        2'b00:   load_ext = {{24{~mu_len[2] & mu_rdata[7]}}, mu_rdata[7:0]};
        2'b01:   load_ext = {{16{~mu_len[2] & mu_rdata[15]}}, mu_rdata[15:0]};
        default: load_ext = mu_rdata;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= S_IDLE;
      owner     <= OWN_IF;
      cnt       <= '0;
      beats     <= '0;
      mu_valid  <= 1'b0;
      mu_wr     <= 1'b0;
      mu_addr   <= '0;
      mu_len    <= '0;
      mu_wdata  <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      lsb_done  <= 1'b0;
      lsb_rdata <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last      <= OWN_LSB;
`endif
    end else if (rdy_in) begin
      if (rob_clear) begin
        state    <= S_IDLE;
        cnt      <= '0;
        mu_valid <= 1'b0;
        if_done  <= 1'b0;
        lsb_done <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (if_req || lsb_req) begin
              if (grant_lsb) begin
                owner    <= OWN_LSB;
                mu_wr    <= lsb_wr;
                mu_addr  <= lsb_addr;
                mu_len   <= lsb_len;
                mu_wdata <= lsb_wdata;
                beats    <= beats_for(lsb_len[1:0]);
              end else begin
                owner    <= OWN_IF;
                mu_wr    <= 1'b0;
                mu_addr  <= if_addr;
                mu_len   <= 3'b010;
                mu_wdata <= '0;
                beats    <= 3'd4;
              end
`ifndef MEM_ARB_FIXED_PRIO_EN
              last     <= grant_lsb ? OWN_LSB : OWN_IF;
`endif
              cnt      <= '0;
              mu_valid <= 1'b1;
              state    <= S_BUSY;
            end
          end
          // mu_valid must drop on the final beat; one extra cycle would restart MemUnit.
          S_BUSY: begin
            if (!stall) begin
              if (last_beat) begin
                mu_valid <= 1'b0;
                state    <= S_WAIT;
              end else begin
                cnt <= cnt + 2'd1;
              end
            end
          end
          S_WAIT: begin
            if (mu_ready) begin
              if (owner == OWN_LSB) begin
                lsb_rdata <= load_ext;
                lsb_done  <= 1'b1;
              end else begin
                if_rdata <= mu_rdata;
                if_done  <= 1'b1;
              end
              state <= S_DONE;
            end
          end
          default: begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single byte-serial memory access unit (`MemUnit`) between two requesters: instruction fetch (IF, word reads) and the load/store buffer (LSB, byte/halfword/word, signed or unsigned, read or write).
- Picks one requester per transaction and holds the unit's request for exactly the required number of byte beats.
- Captures the read result and returns it with a one-cycle done pulse.
- Sits between the IF/LSB units and `MemUnit`; honours the `MemUnit` `rdy_in` pause, the UART-full stall and the ROB flush.

## Interface
Parameters:
- `ADDR_W`, 32, address width.

Ports:
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `rdy_in` in 1: global ready; when low, all state freezes.
- `rob_clear` in 1: synchronous flush.
- `io_buffer_full` in 1: UART buffer full, same signal as fed to `MemUnit`.
- `if_req` in 1: IF request, held until `if_done`.
- `if_addr` in ADDR_W: IF word address.
- `if_done` out 1: one-cycle completion pulse.
- `if_rdata` out 32: fetched word, valid while `if_done`.
- `lsb_req` in 1: LSB request, held until `lsb_done`.
- `lsb_wr` in 1: 1 = store.
- `lsb_addr` in ADDR_W: access address.
- `lsb_len` in 3: access length; bit2 = unsigned, [1:0] = 00 byte / 01 half / 10 word.
- `lsb_wdata` in 32: store data.
- `lsb_done` out 1: one-cycle completion pulse.
- `lsb_rdata` out 32: extended load data, valid while `lsb_done`.
- `mu_valid` out 1: to `MemUnit` `valid`.
- `mu_wr` out 1: to `MemUnit` `wr`.
- `mu_addr` out ADDR_W: to `MemUnit` `addr`.
- `mu_len` out 3: to `MemUnit` `len`.
- `mu_wdata` out 32: to `MemUnit` `data_in`.
- `mu_rdata` in 32: from `MemUnit` `data_out`.
- `mu_ready` in 1: from `MemUnit` `ready`.

## Operation
States:
- **IDLE**: no transaction in progress.
  - If a request is pending, choose the winner and latch its wr/addr/len/wdata into the `mu_*` registers; IF always uses wr=0, len=3'b010.
  - Set `beats` to 1, 2 or 4 from len[1:0], clear `cnt`, set `owner`, go to BUSY.
- **BUSY**: `mu_valid`=1.
  - A beat counts in a cycle where `rdy_in`=1 and the access is not stalled.
  - Stall condition: `mu_wr` && `mu_addr[17:16]`==2'b11 && `io_buffer_full`.
  - On a counted beat with `cnt`==`beats`-1, go to WAIT; otherwise increment `cnt`.
- **WAIT**: `mu_valid`=0.
  - When `mu_ready`=1, register `mu_rdata` into the owner's rdata and go to DONE.
- **DONE**: the owner's done output is 1 for this single cycle; then go to IDLE.
  - No grant is made in DONE, so a requester dropping its req the cycle after done is never re-granted.

Arbitration:
- Round-robin using a `last` pointer updated on each grant.
- When both request, the requester not granted last wins.
- `last` resets to LSB, so IF wins the first tie.

Other rules:
- Stores still pass through WAIT/DONE; `lsb_rdata` is don't-care for stores but is driven to 0.
- `rob_clear` (synchronous, after reset): state→IDLE, `cnt`→0, `mu_valid`→0, no done pulse, `last` kept. An in-flight transaction is silently dropped; `MemUnit` is cleared by the same signal.
- `rdy_in`=0: every register holds, including the done outputs.

Reset values: every output is 0, state=IDLE, `cnt`=0, `last`=LSB.

## Timing
Latency, with the request sampled in IDLE at cycle 0:
- `mu_valid` is high for cycles 1..`beats`.
- `mu_ready` arrives at cycle `beats`+1.
- done is high at cycle `beats`+2.
- Word: done at cycle 6. Half: cycle 4. Byte: cycle 3.

Throughput and stalls:
- Back-to-back: the next grant is in the IDLE cycle `beats`+3.
- Each stalled or `rdy_in`-low cycle in BUSY extends `mu_valid` by one cycle and shifts done by one cycle.

Invariant:
- `mu_valid` must fall exactly after the last beat. Holding it one cycle longer restarts `MemUnit`; this is a verified property.

Simultaneous events:
- `mu_ready` together with `rob_clear`: the clear wins; no done pulse.
- A request arriving in DONE waits until IDLE.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: fixed priority; LSB always wins when both request, and `last` is unused.
- Undefined (default): round-robin as described in Operation.

## Test plan
- IF word read at 0x1000 (RAM = 0x11223344 little-endian): `mu_valid` high for cycles 1–4, `if_done` at cycle 6, `if_rdata`=0x11223344.
- LSB `lsb_len`=3'b000 at a byte holding 0x80 → `lsb_rdata`=0xFFFFFF80, `lsb_done` at cycle 3. `lsb_len`=3'b100 at the same byte → 0x00000080.
- IF and LSB request in the same cycle, repeatedly:
  - Round-robin build: grants alternate IF, LSB, IF, ….
  - With `MEM_ARB_FIXED_PRIO_EN`: LSB is granted every time and IF waits until `lsb_req` drops.
- LSB byte store to 0x30000 with `io_buffer_full`=1 for 5 cycles: `mu_valid` is held for 6 cycles, `lsb_done` arrives 5 cycles late, and exactly one write reaches RAM.
- `rob_clear` pulsed at cycle 3 of an IF word read: no `if_done`, `mu_valid`=0 next cycle, and a new LSB request is granted in the following IDLE cycle.
- `rdy_in` low for cycles 2–3 of a word read: `mu_valid` spans cycles 1–6 and `if_done` arrives at cycle 8; `rst_n_in` low mid-BUSY zeroes all outputs immediately, without waiting for a clock edge.
